// File: rtl/divider5_seq.sv
// divider5_seq: sequential unsigned restoring divider, one quotient bit per clock.
// Revision: 1.0
`default_nettype none

module divider5_seq #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic [W-1:0] Q,
   output logic [W-1:0] R,
   output logic         busy,
   output logic         done,
   output logic         dz
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int CW = (W > 1) ? $clog2(W) : 1;

   state_t         state;
   logic [W-1:0]   dvs;
   logic [W-1:0]   quo;
   logic [W-1:0]   rem;
   logic [CW-1:0]  cnt;

   logic [W:0]     trial;
   logic [W-1:0]   quo_nxt;
   logic [W-1:0]   rem_nxt;

   // A clear borrow bit means the shifted remainder covers the divisor.
   always_comb begin
      trial   = {rem, quo[W-1]} - {1'b0, dvs};
      quo_nxt = {quo[W-2:0], ~trial[W]};
      rem_nxt = {rem[W-2:0], quo[W-1]};
      if (!trial[W]) begin
         rem_nxt = trial[W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         dvs   <= '0;
         quo   <= '0;
         rem   <= '0;
         cnt   <= '0;
         Q     <= '0;
         R     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         dz    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  busy <= 1'b1;
                  if (B != '0) begin
                     dvs   <= B;
                     quo   <= A;
                     rem   <= '0;
                     cnt   <= '0;
                     dz    <= 1'b0;
                     state <= CALC;
                  end else begin
                     Q     <= '1;
                     R     <= A;
                     dz    <= 1'b1;
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            CALC: begin
               quo <= quo_nxt;
               rem <= rem_nxt;
               cnt <= cnt + 1'b1;
               if (cnt == CW'(W - 1)) begin
                  Q     <= quo_nxt;
                  R     <= rem_nxt;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_divider5_seq.sv
// tb_divider5_seq: scoreboard bench for divider5_seq with directed vectors and a full sweep.
`default_nettype none

module tb_divider5_seq;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [4:0] A = '0;
   logic [4:0] B = '0;
   logic [4:0] Q;
   logic [4:0] R;
   logic       busy;
   logic       done;
   logic       dz;

   typedef struct packed {
      logic [4:0] q;
      logic [4:0] r;
      logic       dz;
   } exp_t;

   exp_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   last_done_cyc = -1;
   bit   sweep_on = 1'b0;
   bit   sweep_first = 1'b1;
   int   done_seen = 0;

   divider5_seq #(.W(5)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Q     (Q),
      .R     (R),
      .busy  (busy),
      .done  (done),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Monitor: every done pops one expected result.
   always @(negedge clk) begin
      if (!rst && done) begin
         exp_t e;
         done_seen++;
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("Q", int'(Q), int'(e.q));
            chk("R", int'(R), int'(e.r));
            chk("dz", int'(dz), int'(e.dz));
         end
         if (sweep_on) begin
            if (!sweep_first) chk("done_spacing", cyc - last_done_cyc, 7);
            sweep_first = 1'b0;
         end
         last_done_cyc = cyc;
      end
   end

   // One division with a single-cycle start pulse; checks latency and busy length.
   task automatic do_div(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] eq, input logic [4:0] er,
                         input logic edz, input int elat);
      int lat;
      int busy_cnt;
      exp_q.push_back('{q: eq, r: er, dz: edz});
      @(posedge clk); #1;
      A = a; B = b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; A = 5'd0; B = 5'd0;
      lat = 0;
      busy_cnt = 0;
      while (lat < 20) begin
         @(negedge clk);
         lat++;
         if (busy) busy_cnt++;
         if (done) break;
      end
      chk("latency", lat, elat);
      chk("busy_cycles", busy_cnt, elat);
      @(negedge clk);
      chk("busy_after", int'(busy), 0);
      chk("done_after", int'(done), 0);
   endtask

   initial begin
      int d0;
      int bound;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_Q", int'(Q), 0);
      chk("rst_R", int'(R), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_dz", int'(dz), 0);

      do_div(5'd27, 5'd5, 5'd5, 5'd2, 1'b0, 6);
      do_div(5'd31, 5'd1, 5'd31, 5'd0, 1'b0, 6);
      do_div(5'd3, 5'd7, 5'd0, 5'd3, 1'b0, 6);
      do_div(5'd0, 5'd9, 5'd0, 5'd0, 1'b0, 6);
      do_div(5'd13, 5'd0, 5'd31, 5'd13, 1'b1, 1);
      chk("dz_held", int'(dz), 1);
      do_div(5'd10, 5'd3, 5'd3, 5'd1, 1'b0, 6);
      repeat (3) @(negedge clk);
      chk("Q_held", int'(Q), 3);
      chk("R_held", int'(R), 1);

      // Start requests while busy must be ignored.
      exp_q.push_back('{q: 5'd3, r: 5'd2, dz: 1'b0});
      d0 = done_seen;
      @(posedge clk); #1;
      A = 5'd20; B = 5'd6; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      A = 5'd1; B = 5'd1; start = 1'b1;
      repeat (4) @(posedge clk);
      #1 start = 1'b0;
      repeat (15) @(negedge clk);
      chk("busy_start_dones", done_seen - d0, 1);

      // Reset in the third CALC cycle abandons the division.
      @(posedge clk); #1;
      A = 5'd25; B = 5'd4; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_Q", int'(Q), 0);
      chk("midrst_R", int'(R), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_done", int'(done), 0);
      chk("midrst_dz", int'(dz), 0);
      d0 = done_seen;
      repeat (10) @(negedge clk);
      chk("midrst_no_done", done_seen - d0, 0);
      do_div(5'd25, 5'd4, 5'd6, 5'd1, 1'b0, 6);

      // Exhaustive sweep with start held high; operands change right after acceptance.
      sweep_on = 1'b1;
      sweep_first = 1'b1;
      @(posedge clk); #1;
      start = 1'b1;
      for (int a = 0; a < 32; a++) begin
         for (int b = 1; b < 32; b++) begin
            exp_q.push_back('{q: 5'(a / b), r: 5'(a % b), dz: 1'b0});
            A = 5'(a); B = 5'(b);
            @(posedge clk); #1;
            A = 5'(31 - a); B = 5'd0;
            repeat (6) @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      bound = 0;
      while (exp_q.size() != 0 && bound < 50) begin
         @(negedge clk);
         bound++;
      end
      chk("queue_drained", exp_q.size(), 0);
      sweep_on = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
